icache_fetch_port: RTL

- Direct-mapped instruction cache between the instruction fetcher and the word-wide memory controller.
- Accepts one word-aligned fetch at a time. Hits return in 1 cycle; misses refill a whole line from the memory controller, then respond.
- Honours pipeline flush (ROB clear) without corrupting the memory-controller handshake.

---
 rtl/icache_fetch_port_if.sv | 23 ++
 rtl/icache_fetch_port.sv | 128 ++++++++++++
 2 files changed

// File: rtl/icache_fetch_port_if.sv
// Fetch-side and memory-controller-side signal bundle for icache_fetch_port.
// The cache takes the slave view; the fetcher/memory model takes the master view.
interface icache_fetch_port_if;
    logic        if_valid;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_inst;
    logic        clear;
    logic        mc_valid;
    logic [31:0] mc_addr;
    logic        mc_ready;
    logic [31:0] mc_data;

    modport slave (
        input  if_valid, if_addr, clear, mc_ready, mc_data,
        output if_ready, if_inst, mc_valid, mc_addr
    );

    modport master (
        output if_valid, if_addr, clear, mc_ready, mc_data,
        input  if_ready, if_inst, mc_valid, mc_addr
    );
endinterface

// File: rtl/icache_fetch_port.sv
// Direct-mapped instruction cache with in-order whole-line refill.
// Single outstanding fetch; flush during refill lets the refill finish.
module icache_fetch_port #(
    parameter int INDEX_BITS  = 4,
    parameter int OFFSET_BITS = 2
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    icache_fetch_port_if.slave bus
);
    localparam int LINES      = 1 << INDEX_BITS;
    localparam int LINE_WORDS = 1 << OFFSET_BITS;
    localparam int TAG_BITS   = 30 - INDEX_BITS - OFFSET_BITS;
    localparam int WIDX_BITS  = INDEX_BITS + OFFSET_BITS;

    typedef enum logic [1:0] {
        IDLE,
        RESP,
        REFILL
    } state_e;

    state_e                 state_q, state_d;
    logic [31:0]            if_inst_q, if_inst_d;
    logic [TAG_BITS-1:0]    req_tag_q, req_tag_d;
    logic [INDEX_BITS-1:0]  req_idx_q, req_idx_d;
    logic [OFFSET_BITS-1:0] req_off_q, req_off_d;
    logic [OFFSET_BITS-1:0] cnt_q, cnt_d;
    logic                   killed_q, killed_d;
    logic [LINES-1:0]       valid_q, valid_d;

    logic [TAG_BITS-1:0]    tag_mem  [LINES];
    logic [31:0]            data_mem [LINES*LINE_WORDS];

    logic                   data_we;
    logic                   tag_we;

    logic [OFFSET_BITS-1:0] a_off;
    logic [INDEX_BITS-1:0]  a_idx;
    logic [TAG_BITS-1:0]    a_tag;
    logic                   hit;

    assign a_off = bus.if_addr[OFFSET_BITS+1:2];
    assign a_idx = bus.if_addr[OFFSET_BITS+2 +: INDEX_BITS];
    assign a_tag = bus.if_addr[31 -: TAG_BITS];
    assign hit   = valid_q[a_idx] && (tag_mem[a_idx] == a_tag);

    always_comb begin
        state_d   = state_q;
        if_inst_d = if_inst_q;
        req_tag_d = req_tag_q;
        req_idx_d = req_idx_q;
        req_off_d = req_off_q;
        cnt_d     = cnt_q;
        killed_d  = killed_q;
        valid_d   = valid_q;
        data_we   = 1'b0;
        tag_we    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.if_valid && !bus.clear) begin
                    if (hit) begin
                        if_inst_d = data_mem[{a_idx, a_off}];
                        state_d   = RESP;
                    end else begin
                        req_tag_d = a_tag;
                        req_idx_d = a_idx;
                        req_off_d = a_off;
                        cnt_d     = '0;
                        killed_d  = 1'b0;
                        state_d   = REFILL;
                    end
                end
            end
            RESP: state_d = IDLE;
            REFILL: begin
                if (bus.clear) killed_d = 1'b1;
                if (bus.mc_ready) begin
                    data_we = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == req_off_q) if_inst_d = bus.mc_data;
                    // Last word: line becomes usable even if the fetch was flushed.
                    if (cnt_q == OFFSET_BITS'(LINE_WORDS - 1)) begin
                        valid_d[req_idx_q] = 1'b1;
                        tag_we             = 1'b1;
                        state_d = (killed_q || bus.clear) ? IDLE : RESP;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q   <= IDLE;
            if_inst_q <= '0;
            req_tag_q <= '0;
            req_idx_q <= '0;
            req_off_q <= '0;
            cnt_q     <= '0;
            killed_q  <= 1'b0;
            valid_q   <= '0;
        end else if (rdy_in) begin
            state_q   <= state_d;
            if_inst_q <= if_inst_d;
            req_tag_q <= req_tag_d;
            req_idx_q <= req_idx_d;
            req_off_q <= req_off_d;
            cnt_q     <= cnt_d;
            killed_q  <= killed_d;
            valid_q   <= valid_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in && rdy_in) begin
            if (data_we) data_mem[WIDX_BITS'({req_idx_q, cnt_q})] <= bus.mc_data;
            if (tag_we) tag_mem[req_idx_q] <= req_tag_q;
        end
    end

    assign bus.if_ready = (state_q == RESP) && !bus.clear;
    assign bus.if_inst  = if_inst_q;
    assign bus.mc_valid = (state_q == REFILL);
    assign bus.mc_addr  = (state_q == REFILL) ?
                          {req_tag_q, req_idx_q, cnt_q, 2'b00} : 32'h0;
endmodule
